fir_mac_sterownik: RTL and testbench
====================================

Name: fir_mac_sterownik

Overview:
- Sequencing controller for the FIR MAC datapath (multiplier -> adder -> acc_module); one sample in, one filtered sample out per transaction.
- Accepts input samples over a valid/ready handshake and writes each into a circular sample buffer.
- Steps coefficient and sample read addresses through a configurable number of taps and drives the accumulator clear/enable/store strobes.
- Presents the result over a valid/ready output handshake. The external sample and coefficient memories are synchronous-read with 1-cycle latency.

Parameters:
N_TAPS, 32, sample buffer depth and maximum tap count; need not be a power of two.
ADDR_W, 5, address width; ceil(log2(N_TAPS)).
CNT_W, 16, width of the processed-sample counter.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input sample offered
in_ready  out  1  controller can accept a sample
cfg_taps  in  ADDR_W+1  taps for this transaction; sampled at the input handshake
probka_we  out  1  sample buffer write strobe
probka_adres  out  ADDR_W  sample buffer address, write or read
wsp_adres  out  ADDR_W  coefficient memory read address
acc_clr  out  1  to FSM_reset_Acc
acc_en  out  1  to FSM_Acc_en
acc_zapisz  out  1  to FSM_Acc_zapis
out_valid  out  1  FIR_probka_wynik valid
out_ready  in  1  consumer accepts result
busy  out  1  high in every state except IDLE
licznik_probek  out  CNT_W  completed results, wraps at all-ones

Behaviour:
- Reset, when rst=1 at an edge:
  - state=IDLE, wr_ptr=0, licznik_probek=0.
  - Every strobe, address and out_valid is 0, and busy=0.
  - in_ready=0 during the reset cycle.
  - Reset overrides everything; mid-transaction it aborts immediately with no acc_zapisz and no out_valid.
- States: IDLE, MAC, DRAIN, ZAPISZ, WYJ.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (cycle 0), combinationally in the same cycle: probka_we=1, probka_adres=wr_ptr, acc_clr=1.
  - Latch taps_eff: cfg_taps=0 gives 1; cfg_taps>N_TAPS gives N_TAPS; otherwise cfg_taps.
  - k=0, then go to MAC.
- MAC, cycles 1..T with T=taps_eff:
  - wsp_adres=k.
  - probka_adres=(wr_ptr-k) mod N_TAPS, so newest sample pairs with coefficient 0 and the address wraps below 0 to N_TAPS-1.
  - k increments each cycle; after issuing k=T-1, go to DRAIN.
- acc_en is a 1-cycle-delayed copy of "address issued": high in cycles 2..T+1, exactly T cycles.
- DRAIN: cycle T+1; acc_en=1 for the last product; go to ZAPISZ.
- ZAPISZ: cycle T+2; acc_zapisz=1 for one cycle; go to WYJ.
- WYJ:
  - out_valid=1 from cycle T+3, held until out_ready=1 at an edge.
  - At that edge: out_valid drops next cycle; wr_ptr=(wr_ptr+1) mod N_TAPS, wrapping N_TAPS-1 to 0; licznik_probek+1; go to IDLE.
- Latency:
  - Handshake to out_valid is T+3 cycles.
  - Minimum sample period is T+4 cycles with out_ready tied high.
- in_ready=0 in every non-IDLE state; in_valid there is ignored and the sample stays with the producer.
- out_ready while out_valid=0 has no effect.
- cfg_taps changes after the handshake have no effect on the current transaction.
- All outputs are registered, except in_ready and the IDLE handshake strobes, which decode state and in_valid.
- Initial buffer contents are the datapath owner's concern; the controller does not clear memories.

Test Plan:
1. N_TAPS=4, cfg_taps=4, out_ready=1, handshake at cycle 0, wr_ptr=0 -> probka_we cycle 0 addr 0; cycles 1..4 wsp_adres 0,1,2,3 and probka_adres 0,3,2,1; acc_en cycles 2..5 only; acc_zapisz cycle 6; out_valid cycle 7; licznik_probek=1; wr_ptr=1.
2. Five back-to-back samples, N_TAPS=4 -> write addresses 0,1,2,3,0; fifth transaction reads 0,3,2,1; licznik_probek=5; in_ready low during each transaction.
3. cfg_taps=0 -> one MAC cycle, acc_en one cycle, out_valid at cycle 4. cfg_taps=7 with N_TAPS=4 -> clamped, exactly 4 acc_en cycles.
4. out_ready low for 10 cycles after out_valid -> out_valid held steady, in_ready stays 0 and in_valid is ignored; result accepted on the out_ready cycle; back in IDLE next cycle.
5. rst=1 at cycle 3 of a MAC run -> next cycle all outputs 0, busy=0, wr_ptr=0, licznik_probek=0; no acc_zapisz or out_valid; in_ready=1 once rst is low.
6. Full datapath with u_acc, u_adder and u_multiplier: samples 0.5,0.25 (Q15) with coefficients all 0.5, cfg_taps=2 -> second result 0.375 in Q15 on fir_probka_wynik with out_valid.

Source files
------------

// File: rtl/fir_mac_sterownik.sv
// Sequencing controller for the FIR MAC datapath: accepts one sample, walks the
// taps through the sample/coefficient memories, strobes the accumulator and hands out the result.
module fir_mac_sterownik #(
    parameter int N_TAPS = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W:0]   cfg_taps,
    output logic              probka_we,
    output logic [ADDR_W-1:0] probka_adres,
    output logic [ADDR_W-1:0] wsp_adres,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              acc_zapisz,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  licznik_probek
);

    typedef enum logic [2:0] {IDLE, MAC, DRAIN, ZAPISZ, WYJ} state_t;

    localparam logic [ADDR_W:0]   TAPS_MAX  = (ADDR_W+1)'(N_TAPS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_TAPS - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] k_last;
    logic [ADDR_W-1:0] rd_adres;
    logic [ADDR_W:0]   taps_eff;
    logic              handshake;

    // Zero taps would never issue an address, so it is treated as a single tap.
    always_comb begin
        if (cfg_taps == '0)
            taps_eff = (ADDR_W+1)'(1);
        else if (cfg_taps > TAPS_MAX)
            taps_eff = TAPS_MAX;
        else
            taps_eff = cfg_taps;
    end

    assign in_ready     = (state == IDLE) && !rst;
    assign handshake    = in_ready && in_valid;
    assign probka_we    = handshake;
    assign acc_clr      = handshake;
    assign probka_adres = handshake ? wr_ptr : rd_adres;

    // wsp_adres doubles as the tap index; rd_adres walks backwards from the newest sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            k_last         <= '0;
            rd_adres       <= '0;
            wsp_adres      <= '0;
            acc_en         <= 1'b0;
            acc_zapisz     <= 1'b0;
            out_valid      <= 1'b0;
            busy           <= 1'b0;
            licznik_probek <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        k_last    <= ADDR_W'(taps_eff - (ADDR_W+1)'(1));
                        wsp_adres <= '0;
                        rd_adres  <= wr_ptr;
                        busy      <= 1'b1;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    acc_en <= 1'b1;
                    if (wsp_adres == k_last) begin
                        wsp_adres <= '0;
                        rd_adres  <= '0;
                        state     <= DRAIN;
                    end else begin
                        wsp_adres <= wsp_adres + 1'b1;
                        rd_adres  <= (rd_adres == '0) ? ADDR_LAST : rd_adres - 1'b1;
                    end
                end
                DRAIN: begin
                    acc_en     <= 1'b0;
                    acc_zapisz <= 1'b1;
                    state      <= ZAPISZ;
                end
                ZAPISZ: begin
                    acc_zapisz <= 1'b0;
                    out_valid  <= 1'b1;
                    state      <= WYJ;
                end
                WYJ: begin
                    if (out_ready) begin
                        out_valid      <= 1'b0;
                        busy           <= 1'b0;
                        wr_ptr         <= (wr_ptr == ADDR_LAST) ? '0 : wr_ptr + 1'b1;
                        licznik_probek <= licznik_probek + 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sterownik.sv
// Directed bench for fir_mac_sterownik with a 4-tap buffer; inputs change and
// outputs are sampled around the falling edge.
module tb_fir_mac_sterownik;

    localparam int N_TAPS = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W:0]   cfg_taps;
    logic              probka_we;
    logic [ADDR_W-1:0] probka_adres;
    logic [ADDR_W-1:0] wsp_adres;
    logic              acc_clr;
    logic              acc_en;
    logic              acc_zapisz;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic [CNT_W-1:0]  licznik_probek;

    int checks = 0;
    int errors = 0;

    fir_mac_sterownik #(.N_TAPS(N_TAPS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_taps(cfg_taps), .probka_we(probka_we), .probka_adres(probka_adres),
        .wsp_adres(wsp_adres), .acc_clr(acc_clr), .acc_en(acc_en),
        .acc_zapisz(acc_zapisz), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .licznik_probek(licznik_probek)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; cfg_taps = 3'd4;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({in_ready, probka_we, acc_clr, acc_en, acc_zapisz, out_valid, busy} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b expected 0000000",
                     {in_ready, probka_we, acc_clr, acc_en, acc_zapisz, out_valid, busy});
        end
        checks++;
        if ({probka_adres, wsp_adres} !== 4'b0 || licznik_probek !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got addr %0d/%0d cnt %0d expected 0/0/0",
                     probka_adres, wsp_adres, licznik_probek);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        logic [ADDR_W-1:0] pa_tab [4] = '{2'd0, 2'd3, 2'd2, 2'd1};
        @(negedge clk);
        cfg_taps = 3'd4; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if ({in_ready, probka_we, acc_clr} !== 3'b111 || probka_adres !== 2'd0) begin
            errors++;
            $display("[TB] FAIL single_c0: got rdy/we/clr %b addr %0d expected 111 addr 0",
                     {in_ready, probka_we, acc_clr}, probka_adres);
        end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (c <= 4) begin
                checks++;
                if (wsp_adres !== ADDR_W'(c - 1) || probka_adres !== pa_tab[c-1]) begin
                    errors++;
                    $display("[TB] FAIL single_addr c%0d: got wsp %0d pa %0d expected %0d %0d",
                             c, wsp_adres, probka_adres, c - 1, pa_tab[c-1]);
                end
            end
            checks++;
            if (acc_en !== (c >= 2 && c <= 5) || acc_zapisz !== (c == 6) ||
                out_valid !== (c == 7) || in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL single_ctrl c%0d: got en %b zap %b ov %b rdy %b busy %b",
                         c, acc_en, acc_zapisz, out_valid, in_ready, busy);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || licznik_probek !== 16'd1 || probka_adres !== 2'd1) begin
            errors++;
            $display("[TB] FAIL single_done: got ov %b cnt %0d wr %0d expected 0 1 1",
                     out_valid, licznik_probek, probka_adres);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] wr_tab [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [ADDR_W-1:0] rd_tab [4] = '{2'd0, 2'd3, 2'd2, 2'd1};
        do_reset();
        cfg_taps = 3'd4; out_ready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            checks++;
            if (probka_we !== 1'b1 || probka_adres !== wr_tab[s]) begin
                errors++;
                $display("[TB] FAIL b2b_write s%0d: got we %b addr %0d expected 1 %0d",
                         s, probka_we, probka_adres, wr_tab[s]);
            end
            for (int c = 1; c <= 7; c++) begin
                @(negedge clk); #1;
                if (in_ready !== 1'b0 || probka_we !== 1'b0) begin
                    checks++; errors++;
                    $display("[TB] FAIL b2b_ready s%0d c%0d: got rdy %b we %b expected 0 0",
                             s, c, in_ready, probka_we);
                end
                if (s == 4 && c <= 4) begin
                    checks++;
                    if (probka_adres !== rd_tab[c-1]) begin
                        errors++;
                        $display("[TB] FAIL b2b_read c%0d: got %0d expected %0d",
                                 c, probka_adres, rd_tab[c-1]);
                    end
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (licznik_probek !== 16'd5 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_count: got cnt %0d rdy %b expected 5 1", licznik_probek, in_ready);
        end
    endtask

    task automatic test_taps_edge();
        int en_cnt;
        int ov_first;
        do_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            cfg_taps = (t == 0) ? 3'd0 : 3'd7;
            in_valid = 1'b1;
            en_cnt = 0; ov_first = -1;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                cfg_taps = 3'd3;
                #1;
                if (acc_en === 1'b1) en_cnt++;
                if (out_valid === 1'b1 && ov_first < 0) ov_first = c;
            end
            checks++;
            if (en_cnt != ((t == 0) ? 1 : 4) || ov_first != ((t == 0) ? 4 : 7)) begin
                errors++;
                $display("[TB] FAIL taps_edge t%0d: got en %0d ov@%0d expected %0d ov@%0d",
                         t, en_cnt, ov_first, (t == 0) ? 1 : 4, (t == 0) ? 4 : 7);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        cfg_taps = 3'd2; in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = (c <= 4);
            #1;
        end
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_first: got ov %b busy %b expected 1 1 at cycle 5", out_valid, busy);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || probka_we !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold h%0d: got ov %b rdy %b we %b expected 1 0 0",
                         c, out_valid, in_ready, probka_we);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || licznik_probek !== 16'd1) begin
            errors++;
            $display("[TB] FAIL bp_accept: got ov %b busy %b rdy %b cnt %0d expected 0 0 1 1",
                     out_valid, busy, in_ready, licznik_probek);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        cfg_taps = 3'd4; in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({in_ready, probka_we, acc_clr, acc_en, acc_zapisz, out_valid, busy} !== 7'b0 ||
            {probka_adres, wsp_adres} !== 4'b0 || licznik_probek !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got ctl %b addr %0d/%0d cnt %0d expected all 0",
                     {in_ready, probka_we, acc_clr, acc_en, acc_zapisz, out_valid, busy},
                     probka_adres, wsp_adres, licznik_probek);
        end
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (acc_zapisz === 1'b1 || out_valid === 1'b1) seen++;
        end
        in_valid = 1'b1;
        #1;
        checks++;
        if (seen != 0 || in_ready !== 1'b1 || probka_adres !== 2'd0) begin
            errors++;
            $display("[TB] FAIL mid_after: got strobes %0d rdy %b wr %0d expected 0 1 0",
                     seen, in_ready, probka_adres);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_taps_edge();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
